// File: rtl/vram_arb_if.sv
// Requester handshakes, VRAM macro pins and status of the display VRAM arbiter.
// The master modport is the arbiter's view; slave is the surrounding system.
interface vram_arb_if #(
    parameter int AW = 13,
    parameter int DW = 8
);
    logic          arb_en;
    logic          disp_req;
    logic [AW-1:0] disp_addr;
    logic          disp_ack;
    logic [DW-1:0] disp_rdata;
    logic          disp_rvalid;
    logic          stn_req;
    logic [AW-1:0] stn_addr;
    logic          stn_ack;
    logic [DW-1:0] stn_rdata;
    logic          stn_rvalid;
    logic          host_req;
    logic          host_we;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_wdata;
    logic          host_ack;
    logic [DW-1:0] host_rdata;
    logic          host_rvalid;
    logic          ram_cs;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;
    logic          err_clr;
    logic          ovr_err;

    modport master (
        input  arb_en, disp_req, disp_addr, stn_req, stn_addr,
               host_req, host_we, host_addr, host_wdata, ram_rdata, err_clr,
        output disp_ack, disp_rdata, disp_rvalid, stn_ack, stn_rdata, stn_rvalid,
               host_ack, host_rdata, host_rvalid, ram_cs, ram_we, ram_addr,
               ram_wdata, ovr_err
    );

    modport slave (
        output arb_en, disp_req, disp_addr, stn_req, stn_addr,
               host_req, host_we, host_addr, host_wdata, ram_rdata, err_clr,
        input  disp_ack, disp_rdata, disp_rvalid, stn_ack, stn_rdata, stn_rvalid,
               host_ack, host_rdata, host_rvalid, ram_cs, ram_we, ram_addr,
               ram_wdata, ovr_err
    );
endinterface

// File: rtl/vram_arb.sv
// Three-way arbiter for the single-port display VRAM: display > STN/host round-robin,
// one RAM access every two clocks, read data routed back to the owning requester.
module vram_arb #(
    parameter int AW            = 13,
    parameter int DW            = 8,
    parameter int DISP_MAX_WAIT = 4
) (
    input logic        clk,
    input logic        rst,
    vram_arb_if.master bus
);
    typedef enum logic {IDLE, ACCESS} state_t;

    state_t     state, state_nxt;
    logic       gnt_disp, gnt_stn, gnt_host;
    logic       stn_turn;          // 1: STN wins the next STN/host tie
    logic       rd_vld_p1;
    logic [2:0] rd_own_p1;         // one-hot {host, stn, disp}
    logic [3:0] wd_cnt;
    logic       wd_run, wd_ovf;

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

    // Request inputs are only looked at from IDLE, so a held req cannot be granted twice.
    always_comb begin
        state_nxt = state;
        gnt_disp  = 1'b0;
        gnt_stn   = 1'b0;
        gnt_host  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.arb_en) begin
                    if (bus.disp_req)
                        gnt_disp = 1'b1;
                    else if (bus.stn_req && (stn_turn || !bus.host_req))
                        gnt_stn = 1'b1;
                    else if (bus.host_req)
                        gnt_host = 1'b1;
                    if (bus.disp_req || bus.stn_req || bus.host_req)
                        state_nxt = ACCESS;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // p0: access issue, registered on the IDLE->ACCESS edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.ram_cs    <= 1'b0;
            bus.ram_we    <= 1'b0;
            bus.disp_ack  <= 1'b0;
            bus.stn_ack   <= 1'b0;
            bus.host_ack  <= 1'b0;
            bus.ram_addr  <= '0;
            bus.ram_wdata <= '0;
            stn_turn      <= 1'b1;
        end else begin
            bus.ram_cs   <= gnt_disp | gnt_stn | gnt_host;
            bus.ram_we   <= gnt_host & bus.host_we;
            bus.disp_ack <= gnt_disp;
            bus.stn_ack  <= gnt_stn;
            bus.host_ack <= gnt_host;
            if (gnt_disp)      bus.ram_addr <= bus.disp_addr;
            else if (gnt_stn)  bus.ram_addr <= bus.stn_addr;
            else if (gnt_host) bus.ram_addr <= bus.host_addr;
            if (gnt_host) bus.ram_wdata <= bus.host_wdata;
            if (gnt_stn)       stn_turn <= 1'b0;
            else if (gnt_host) stn_turn <= 1'b1;
        end
    end

    // p1: RAM read data valid; p2: routed to the owner's rdata/rvalid
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_vld_p1       <= 1'b0;
            rd_own_p1       <= '0;
            bus.disp_rvalid <= 1'b0;
            bus.stn_rvalid  <= 1'b0;
            bus.host_rvalid <= 1'b0;
            bus.disp_rdata  <= '0;
            bus.stn_rdata   <= '0;
            bus.host_rdata  <= '0;
        end else begin
            rd_vld_p1       <= bus.ram_cs & ~bus.ram_we;
            rd_own_p1       <= {bus.host_ack, bus.stn_ack, bus.disp_ack};
            bus.disp_rvalid <= rd_vld_p1 & rd_own_p1[0];
            bus.stn_rvalid  <= rd_vld_p1 & rd_own_p1[1];
            bus.host_rvalid <= rd_vld_p1 & rd_own_p1[2];
            if (rd_vld_p1 & rd_own_p1[0]) bus.disp_rdata <= bus.ram_rdata;
            if (rd_vld_p1 & rd_own_p1[1]) bus.stn_rdata  <= bus.ram_rdata;
            if (rd_vld_p1 & rd_own_p1[2]) bus.host_rdata <= bus.ram_rdata;
        end
    end

    // Display starvation watchdog; a fresh overflow beats a simultaneous clear.
    assign wd_run = bus.disp_req & ~bus.disp_ack;
    assign wd_ovf = wd_run && (wd_cnt == 4'(DISP_MAX_WAIT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_cnt      <= '0;
            bus.ovr_err <= 1'b0;
        end else begin
            wd_cnt <= wd_run ? sat_inc(wd_cnt) : 4'd0;
            if (wd_ovf)           bus.ovr_err <= 1'b1;
            else if (bus.err_clr) bus.ovr_err <= 1'b0;
        end
    end
endmodule

// File: tb/tb_vram_arb.sv
// Bench for vram_arb: directed scenarios plus random traffic, all scored against a
// transaction-level reference model with its own shadow memory and a read-return queue.
module tb_vram_arb;
    localparam int AW   = 13;
    localparam int DW   = 8;
    localparam int MAXW = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    vram_arb_if #(.AW(AW), .DW(DW)) bus();

    vram_arb #(.AW(AW), .DW(DW), .DISP_MAX_WAIT(MAXW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // VRAM macro: read data valid the clock after chip select
    logic [DW-1:0] mem     [0:(1<<AW)-1];
    logic [DW-1:0] mdl_mem [0:(1<<AW)-1];

    always @(posedge clk) begin
        if (bus.ram_cs) begin
            if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
            else            bus.ram_rdata     <= mem[bus.ram_addr];
        end
    end

    // Reference model: expected values of every registered output for the current cycle
    typedef struct packed {
        int unsigned   due;
        logic [1:0]    own;
        logic [DW-1:0] data;
    } ret_t;

    ret_t          ret_q[$];
    int unsigned   edge_n = 0;
    logic          m_busy = 1'b0;
    logic          m_stn_turn = 1'b1;
    int            m_wait = 0;
    logic          m_pw = 1'b0;
    logic [AW-1:0] m_pw_addr = '0;
    logic [DW-1:0] m_pw_data = '0;
    logic          e_cs = 1'b0, e_we = 1'b0, e_err = 1'b0;
    logic [AW-1:0] e_addr = '0;
    logic [DW-1:0] e_wdata = '0;
    logic [2:0]    e_ack = '0, e_rv = '0;
    logic [DW-1:0] e_rd [3] = '{default: '0};

    always @(posedge clk or posedge rst) begin : model
        int   w;
        logic set;
        if (rst) begin
            m_busy = 1'b0; m_stn_turn = 1'b1; m_wait = 0; m_pw = 1'b0;
            e_cs = 1'b0; e_we = 1'b0; e_err = 1'b0; e_ack = '0; e_rv = '0;
            e_rd = '{default: '0};
            ret_q.delete();
        end else begin
            edge_n++;
            if (m_pw) mdl_mem[m_pw_addr] = m_pw_data;
            m_pw = 1'b0;
            set = 1'b0;
            if (bus.disp_req && !e_ack[0]) begin
                if (m_wait < 15) begin
                    m_wait++;
                    set = (m_wait == MAXW);
                end
            end else begin
                m_wait = 0;
            end
            if (set)              e_err = 1'b1;
            else if (bus.err_clr) e_err = 1'b0;

            w = -1;
            if (!m_busy && bus.arb_en) begin
                if (bus.disp_req)                     w = 0;
                else if (bus.stn_req && bus.host_req) w = m_stn_turn ? 1 : 2;
                else if (bus.stn_req)                 w = 1;
                else if (bus.host_req)                w = 2;
            end
            e_ack = '0; e_cs = 1'b0; e_we = 1'b0;
            if (w >= 0) begin
                m_busy = 1'b1;
                e_cs = 1'b1;
                e_ack[w] = 1'b1;
                e_addr = (w == 0) ? bus.disp_addr : (w == 1) ? bus.stn_addr : bus.host_addr;
                if (w == 2 && bus.host_we) begin
                    e_we = 1'b1; e_wdata = bus.host_wdata;
                    m_pw = 1'b1; m_pw_addr = e_addr; m_pw_data = bus.host_wdata;
                end else begin
                    ret_q.push_back('{due: edge_n + 2, own: 2'(w), data: mdl_mem[e_addr]});
                end
                if (w == 1) m_stn_turn = 1'b0;
                if (w == 2) m_stn_turn = 1'b1;
            end else begin
                m_busy = 1'b0;
            end

            e_rv = '0;
            if (ret_q.size() > 0 && ret_q[0].due == edge_n) begin
                e_rv[ret_q[0].own] = 1'b1;
                e_rd[ret_q[0].own] = ret_q[0].data;
                void'(ret_q.pop_front());
            end
        end
    end

    logic prev_cs = 1'b0;
    always @(negedge clk) begin
        check_eq("ram_cs", bus.ram_cs, e_cs);
        check_eq("ram_we", bus.ram_we, e_we);
        if (e_cs) check_eq("ram_addr", bus.ram_addr, e_addr);
        if (e_we) check_eq("ram_wdata", bus.ram_wdata, e_wdata);
        check_eq("acks", {bus.host_ack, bus.stn_ack, bus.disp_ack}, e_ack);
        check_eq("rvalids", {bus.host_rvalid, bus.stn_rvalid, bus.disp_rvalid}, e_rv);
        check_eq("disp_rdata", bus.disp_rdata, e_rd[0]);
        check_eq("stn_rdata", bus.stn_rdata, e_rd[1]);
        check_eq("host_rdata", bus.host_rdata, e_rd[2]);
        check_eq("ovr_err", bus.ovr_err, e_err);
        check_eq("cs_b2b", prev_cs & bus.ram_cs, 0);
        prev_cs = bus.ram_cs;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    int         n_disp;
    logic [7:0] seq;

    initial begin
        for (int i = 0; i < (1 << AW); i++) begin
            mem[i]     = 8'(i * 37 + 11);
            mdl_mem[i] = 8'(i * 37 + 11);
        end
        mem[13'h0123]     = 8'hA5;
        mdl_mem[13'h0123] = 8'hA5;
        bus.arb_en = 1'b1; bus.err_clr = 1'b0;
        bus.disp_req = 1'b0; bus.disp_addr = '0;
        bus.stn_req = 1'b0; bus.stn_addr = '0;
        bus.host_req = 1'b0; bus.host_we = 1'b0; bus.host_addr = '0; bus.host_wdata = '0;
        #1 rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // single display read
        bus.disp_addr = 13'h0123; bus.disp_req = 1'b1;
        tick();
        check_eq("disp_ack_c1", bus.disp_ack, 1);
        check_eq("ram_addr_c1", bus.ram_addr, 13'h0123);
        bus.disp_req = 1'b0;
        tick(); tick();
        check_eq("disp_rvalid_c3", bus.disp_rvalid, 1);
        check_eq("disp_rdata_a5", bus.disp_rdata, 8'hA5);

        // reset in the middle of a read access
        tick();
        bus.disp_addr = 13'h0456; bus.disp_req = 1'b1;
        tick();
        check_eq("pre_rst_ack", bus.disp_ack, 1);
        rst = 1'b1; bus.disp_req = 1'b0;
        #1;
        check_eq("rst_cs", bus.ram_cs, 0);
        check_eq("rst_ack", bus.disp_ack, 0);
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check_eq("rst_rdata", bus.disp_rdata, 0);

        // STN/host tie right after reset
        bus.stn_addr = 13'h0A01; bus.stn_req = 1'b1;
        bus.host_addr = 13'h1B02; bus.host_we = 1'b0; bus.host_req = 1'b1;
        tick();
        check_eq("tie_stn_first", {bus.host_ack, bus.stn_ack}, 2'b01);
        bus.stn_req = 1'b0;
        tick(); tick();
        check_eq("tie_host_next", bus.host_ack, 1);
        bus.host_req = 1'b0;
        tick();

        // three-way contention
        bus.disp_addr = 13'h0042; bus.disp_req = 1'b1;
        bus.stn_req = 1'b1; bus.host_req = 1'b1;
        n_disp = 0; seq = '0;
        for (int i = 1; i <= 16; i++) begin
            tick();
            if (bus.disp_ack) n_disp++;
            if (bus.stn_ack)  seq = {seq[5:0], 2'd1};
            if (bus.host_ack) seq = {seq[5:0], 2'd2};
            if (i == 8) bus.disp_req = 1'b0;
        end
        check_eq("cont_disp_grants", n_disp, 4);
        check_eq("cont_rr_order", seq, 8'h66);
        bus.stn_req = 1'b0; bus.host_req = 1'b0;
        tick(); tick();

        // host write then read back
        bus.host_addr = 13'h17BF; bus.host_wdata = 8'h5A; bus.host_we = 1'b1; bus.host_req = 1'b1;
        tick();
        check_eq("hw_ack", bus.host_ack, 1);
        check_eq("hw_we", bus.ram_we, 1);
        bus.host_req = 1'b0; bus.host_we = 1'b0;
        tick();
        bus.host_req = 1'b1;
        tick();
        check_eq("hr_ack", bus.host_ack, 1);
        check_eq("hr_we", bus.ram_we, 0);
        bus.host_req = 1'b0;
        tick(); tick();
        check_eq("hr_rvalid", bus.host_rvalid, 1);
        check_eq("hr_rdata", bus.host_rdata, 8'h5A);
        tick();

        // starvation watchdog with grants disabled
        bus.arb_en = 1'b0; bus.disp_addr = 13'h0AAA; bus.disp_req = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            tick();
            check_eq("wd_no_cs", bus.ram_cs, 0);
            if (i == 3) check_eq("wd_err_c3", bus.ovr_err, 0);
            if (i == 4) check_eq("wd_err_c4", bus.ovr_err, 1);
        end
        bus.arb_en = 1'b1; bus.err_clr = 1'b1;
        tick();
        bus.err_clr = 1'b0;
        check_eq("wd_grant", bus.disp_ack, 1);
        check_eq("wd_cleared", bus.ovr_err, 0);
        bus.disp_req = 1'b0;
        tick(); tick();

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            if (c == 1500) begin
                rst = 1'b1;
                bus.disp_req = 1'b0; bus.stn_req = 1'b0; bus.host_req = 1'b0;
            end else begin
                rst = 1'b0;
                bus.arb_en  = ($urandom_range(0, 15) != 0);
                bus.err_clr = ($urandom_range(0, 7) == 0);
                if (bus.disp_ack) bus.disp_req = 1'b0;
                if (bus.stn_ack)  bus.stn_req  = 1'b0;
                if (bus.host_ack) bus.host_req = 1'b0;
                if (!bus.disp_req && $urandom_range(0, 9) == 0) begin
                    bus.disp_req = 1'b1; bus.disp_addr = AW'($urandom);
                end
                if (!bus.stn_req && $urandom_range(0, 2) == 0) begin
                    bus.stn_req = 1'b1; bus.stn_addr = AW'($urandom);
                end
                if (!bus.host_req && $urandom_range(0, 2) == 0) begin
                    bus.host_req   = 1'b1;
                    bus.host_we    = 1'($urandom_range(0, 1));
                    bus.host_addr  = AW'($urandom_range(0, 63));
                    bus.host_wdata = DW'($urandom);
                end
            end
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/vram_arb.md
Name: vram_arb

Overview:
- Arbiter/sequencer for the single-port 8K x 8 display VRAM.
- Shares the VRAM among three requesters:
  - TFT timing-generator read port (highest priority).
  - STN refresh read port.
  - Host MPU read/write port.
- Sits between the LCD timing generators, the host interface and the VRAM macro. Issues one RAM access per two clocks and returns read data to the owning requester.

Parameters:
AW, 13, VRAM address width
DW, 8, VRAM data width
DISP_MAX_WAIT, 4, clocks disp_req may stay unacknowledged before ovr_err sets (4..15)

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active high
arb_en  in  1  1 = grants allowed; 0 = no new grant issued
disp_req  in  1  display read request; held until ack
disp_addr  in  AW  display read address
disp_ack  out  1  one-clock grant/accept pulse
disp_rdata  out  DW  display read data
disp_rvalid  out  1  one-clock pulse, disp_rdata valid
stn_req  in  1  STN read request
stn_addr  in  AW  STN read address
stn_ack  out  1  grant pulse
stn_rdata  out  DW  STN read data
stn_rvalid  out  1  STN read data valid pulse
host_req  in  1  host access request
host_we  in  1  1 = write, 0 = read
host_addr  in  AW  host address
host_wdata  in  DW  host write data
host_ack  out  1  grant pulse
host_rdata  out  DW  host read data
host_rvalid  out  1  host read data valid pulse (reads only)
ram_cs  out  1  VRAM chip select, one clock per access
ram_we  out  1  VRAM write enable
ram_addr  out  AW  VRAM address
ram_wdata  out  DW  VRAM write data
ram_rdata  in  DW  VRAM read data, valid the clock after ram_cs
err_clr  in  1  clears ovr_err
ovr_err  out  1  sticky display-starvation flag

Behaviour:
- Reset (rst=1, async):
  - FSM enters IDLE.
  - All *_ack, *_rvalid, ram_cs, ram_we and ovr_err go to 0.
  - All *_rdata, ram_addr, ram_wdata go to 0.
  - Round-robin pointer set so STN wins the first STN/host tie.
  - Pending read return discarded.
- FSM, two states:
  - IDLE: if arb_en=1 and any request is high, latch the winner's id, address, we and wdata; next state ACCESS. Otherwise stay in IDLE.
  - ACCESS: ram_cs=1, ram_we=latched we, ram_addr/ram_wdata = latched values, winner's *_ack=1. Next state is always IDLE.
  - Peak throughput is one access per 2 clocks.
- All outputs are registered. ram_cs/ram_we/*_ack are high only in the ACCESS cycle.
- Priority:
  - disp_req always wins.
  - STN vs host uses round-robin: the one not granted last wins a tie.
  - Pointer updates only on an STN or host grant.
- Read return:
  - A read in ACCESS cycle k makes ram_rdata valid in cycle k+1.
  - The arbiter registers it into the owner's *_rdata at the k+2 edge and pulses the owner's *_rvalid for cycle k+2.
  - Latency from request sampled to rvalid is 3 clocks.
  - *_rdata holds until that owner's next read.
  - Writes produce no rvalid.
- Requester protocol:
  - Hold *_req and the address/data stable until the *_ack cycle, and drop or change them after it.
  - The arbiter never samples request inputs during ACCESS, so a held req is not double-granted.
  - A req dropped before grant is ignored.
  - Inputs changed during ACCESS do not affect the access in progress.
- arb_en=0: no new grant from IDLE. An access already in ACCESS and its read return complete normally.
- Watchdog:
  - A 4-bit counter counts clocks with disp_req=1 and disp_ack=0. It clears on disp_ack or disp_req=0.
  - When the count reaches DISP_MAX_WAIT, ovr_err sets.
  - ovr_err stays set until err_clr=1. If err_clr and a new overflow occur in the same clock, the set wins.
- Address passes through unmodified. No range check; VRAM wraps at 2^AW.

Test Plan:
- Reset: assert rst mid-ACCESS with a read pending -> same cycle ram_cs=0, disp_ack=0. No rvalid follows. All rdata=0 after release.
- Single display read: disp_req=1, disp_addr=0x0123, ram returns 0xA5 -> disp_ack in cycle 1, ram_cs=1 with ram_addr=0x0123, disp_rvalid=1 in cycle 3, disp_rdata=0xA5.
- Three-way contention, all reqs high continuously:
  - Grant order is disp, disp, ...; when disp drops, grants alternate stn, host, stn.
  - ram_cs is never high on two consecutive clocks.
- Host write then read: write 0x5A to 0x17BF, then read 0x17BF -> ram_we=1 only on the write access, host_rvalid only on the read with host_rdata=0x5A, no stn/disp pulses.
- arb_en=0 with disp_req held 6 clocks, DISP_MAX_WAIT=4 -> no ram_cs, ovr_err=1 after 4 clocks. Set arb_en=1 and pulse err_clr -> grant follows, ovr_err=0.
- STN/host tie after reset: both request simultaneously -> stn_ack first, then host_ack two clocks later.
